// File: rtl/clken_nco_bank.sv
// clken_nco_bank: bank of NUM_CH phase-accumulator clock-enable generators on
// a single reference clock. Channel i emits one-cycle enables at
// f_refclk * inc[i] / 2^ACC_W.
//
// Ports:
//   refclk  - reference clock (only clock in the block)
//   rst     - synchronous reset, active-high; overrides cfg_we and resync
//   cfg_we  - write strobe: load cfg_inc into channel cfg_ch
//   cfg_ch  - target channel; writes to cfg_ch >= NUM_CH are ignored
//   cfg_inc - new phase increment
//   cfg_ack - one-cycle pulse the cycle after an accepted write
//   resync  - clear every accumulator together
//   ce      - per-channel registered clock-enable pulses
//   locked  - high once LOCK_CYC quiet cycles follow reset/write/resync
//   outclk  - per-channel divide-by-two of ce (only with CLKOUT_TOGGLE_EN)
//
// Optional feature macro: CLKOUT_TOGGLE_EN adds the outclk toggle outputs.
module clken_nco_bank #(
  parameter int unsigned NUM_CH   = 6,
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned LOCK_CYC = 256,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC = '0
) (
  input  logic                                            refclk,
  input  logic                                            rst,
  input  logic                                            cfg_we,
  input  logic [$clog2((NUM_CH > 1) ? NUM_CH : 2)-1:0]    cfg_ch,
  input  logic [ACC_W-1:0]                                cfg_inc,
  output logic                                            cfg_ack,
  input  logic                                            resync,
  output logic [NUM_CH-1:0]                               ce,
  output logic                                            locked
`ifdef CLKOUT_TOGGLE_EN
  ,
  output logic [NUM_CH-1:0]                               outclk
`endif
);

  localparam int unsigned CH_W = $clog2((NUM_CH > 1) ? NUM_CH : 2);
  localparam int unsigned LC_W = $clog2(LOCK_CYC + 1);

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] inc [NUM_CH];
  logic [ACC_W:0]   sum [NUM_CH];
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] ch_clr;
  logic              wr_valid;
  logic              disturb;
  logic [LC_W-1:0]   lock_cnt;
  logic [LC_W-1:0]   lock_cnt_nxt;

  // Write decode, per-channel accumulator sums and lock counter next value
  always_comb begin
    wr_valid = cfg_we && (32'(cfg_ch) < NUM_CH);
    disturb  = wr_valid || resync;
    ch_hit   = '0;
    ch_clr   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i]    = {1'b0, acc[i]} + {1'b0, inc[i]};
      ch_hit[i] = wr_valid && (cfg_ch == CH_W'(i));
      ch_clr[i] = resync || ch_hit[i];
    end
    if (disturb) begin
      lock_cnt_nxt = '0;
    end else if (lock_cnt == LC_W'(LOCK_CYC)) begin
      lock_cnt_nxt = lock_cnt;
    end else begin
      lock_cnt_nxt = lock_cnt + LC_W'(1);
    end
  end

  // Accumulators, increments and registered carry-out enables
  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        inc[i] <= INIT_INC[i*ACC_W +: ACC_W];
      end
      ce <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_clr[i]) begin
          acc[i] <= '0;
          ce[i]  <= 1'b0;
        end else begin
          acc[i] <= sum[i][ACC_W-1:0];
          ce[i]  <= sum[i][ACC_W];
        end
        if (ch_hit[i]) begin
          inc[i] <= cfg_inc;
        end
      end
    end
  end

  // Write acknowledge and lock indication; locked rises on the same edge
  // the counter reaches LOCK_CYC
  always_ff @(posedge refclk) begin
    if (rst) begin
      cfg_ack  <= 1'b0;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      cfg_ack  <= wr_valid;
      lock_cnt <= lock_cnt_nxt;
      locked   <= (lock_cnt_nxt == LC_W'(LOCK_CYC));
    end
  end

`ifdef CLKOUT_TOGGLE_EN
  // Divide-by-two of each enable: toggles on every edge that sets ce
  always_ff @(posedge refclk) begin
    if (rst) begin
      outclk <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_clr[i]) begin
          outclk[i] <= 1'b0;
        end else if (sum[i][ACC_W]) begin
          outclk[i] <= ~outclk[i];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_clken_nco_bank.sv
// Directed bench for clken_nco_bank: NUM_CH=6, ACC_W=24, LOCK_CYC=256,
// channel 0 resets to increment 0x800000 (half rate), all others to 0.
module tb_clken_nco_bank;

  localparam int unsigned NUM_CH   = 6;
  localparam int unsigned ACC_W    = 24;
  localparam int unsigned LOCK_CYC = 256;
  localparam logic [NUM_CH*ACC_W-1:0] INIT_INC = {{(NUM_CH-1)*ACC_W{1'b0}}, 24'h800000};

  logic              refclk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [2:0]        cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic              cfg_ack;
  logic              resync;
  logic [NUM_CH-1:0] ce;
  logic              locked;
`ifdef CLKOUT_TOGGLE_EN
  logic [NUM_CH-1:0] outclk;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] pat_a;
  logic [15:0] pat_b;
  logic [15:0] pat_c;
  logic [NUM_CH-1:0] ce_or;

  clken_nco_bank #(
    .NUM_CH   (NUM_CH),
    .ACC_W    (ACC_W),
    .LOCK_CYC (LOCK_CYC),
    .INIT_INC (INIT_INC)
  ) dut (
    .refclk  (refclk),
    .rst     (rst),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_inc (cfg_inc),
    .cfg_ack (cfg_ack),
    .resync  (resync),
    .ce      (ce),
    .locked  (locked)
`ifdef CLKOUT_TOGGLE_EN
    ,
    .outclk  (outclk)
`endif
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0; resync = 1'b0;

    // Reset state
    ticks(3);
    check("rst_ce", 32'(ce), 32'h0);
    check("rst_ack", 32'(cfg_ack), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);

    // Release: ch0 half rate, first enable after edge 2
    rst = 1'b0;
    pat_a = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      pat_a[k] = ce[0];
      ce_or = ce;
    end
    check("ch0_startup", 32'(pat_a[3:0]), 32'hA);
    ticks(251);                                   // edge 255 after release
    check("lock_pre", 32'(locked), 32'h0);
    tick();                                       // edge 256
    check("lock_post", 32'(locked), 32'h1);
    check("ce_at_256", 32'(ce), 32'h01);

    // Write to non-existent channel 7: ignored
    cfg_we = 1'b1; cfg_ch = 3'd7; cfg_inc = 24'h100000;
    tick();                                       // edge 257
    cfg_we = 1'b0;
    check("bad_ack", 32'(cfg_ack), 32'h0);
    check("bad_locked", 32'(locked), 32'h1);
    check("bad_ce", 32'(ce), 32'h00);
    tick();                                       // edge 258
    check("bad_ce_next", 32'(ce), 32'h01);

    // Write ch2 = 1/8 rate
    cfg_we = 1'b1; cfg_ch = 3'd2; cfg_inc = 24'h200000;
    tick();                                       // edge 259 (W)
    cfg_we = 1'b0;
    check("wr2_ack", 32'(cfg_ack), 32'h1);
    check("wr2_locked", 32'(locked), 32'h0);
    check("wr2_ce", 32'(ce), 32'h00);
    pat_a = '0; pat_b = '0; pat_c = '0;
    for (int k = 0; k < 16; k++) begin
      tick();
      pat_a[k] = ce[2];
      pat_b[k] = ce[0];
      pat_c[k] = cfg_ack;
    end                                           // ends at edge 275
    check("wr2_ce2_pat", 32'(pat_a), 32'h8080);
    check("wr2_ce0_pat", 32'(pat_b), 32'h5555);
    check("wr2_ack_pat", 32'(pat_c), 32'h0000);

    // ch1 = 1/4 rate, written on an odd edge so it runs out of phase with ch0
    tick();                                       // edge 276
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_inc = 24'h400000;
    tick();                                       // edge 277
    cfg_we = 1'b0;
    check("wr1_ack", 32'(cfg_ack), 32'h1);
    ticks(4);                                     // edge 281
    check("pre_resync_ce", 32'(ce), 32'h02);
    tick();                                       // edge 282
    resync = 1'b1;
    tick();                                       // edge 283 (R)
    resync = 1'b0;
    check("resync_ce", 32'(ce), 32'h00);
    check("resync_locked", 32'(locked), 32'h0);
    pat_a = '0; pat_b = '0; pat_c = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      pat_a[k] = ce[0];
      pat_b[k] = ce[1];
      pat_c[k] = ce[2];
    end
    check("rs_ce0_pat", 32'(pat_a[7:0]), 32'hAA);
    check("rs_ce1_pat", 32'(pat_b[7:0]), 32'h88);
    check("rs_ce2_pat", 32'(pat_c[7:0]), 32'h80);
    ticks(247);                                   // R+255
    check("rs_lock_pre", 32'(locked), 32'h0);
    tick();                                       // R+256
    check("rs_lock_post", 32'(locked), 32'h1);

    // Back-to-back writes, reset lands on the third
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_inc = 24'h100000;
    tick();
    cfg_ch = 3'd1; cfg_inc = 24'h100000;
    check("b2b_ack0", 32'(cfg_ack), 32'h1);
    tick();
    check("b2b_ack1", 32'(cfg_ack), 32'h1);
    cfg_ch = 3'd2; cfg_inc = 24'h100000; rst = 1'b1;
    tick();
    cfg_we = 1'b0; rst = 1'b0;
    check("b2b_ack2", 32'(cfg_ack), 32'h0);
    check("b2b_ce", 32'(ce), 32'h00);
    check("b2b_locked", 32'(locked), 32'h0);
    pat_a = '0;
    ce_or = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      pat_a[k] = ce[0];
      ce_or = ce_or | ce;
    end
    check("b2b_ce0_pat", 32'(pat_a[7:0]), 32'hAA);
    check("b2b_others", 32'(ce_or[NUM_CH-1:1]), 32'h0);
    check("b2b_ack_after", 32'(cfg_ack), 32'h0);

`ifdef CLKOUT_TOGGLE_EN
    // ch0 at 1/4 rate: outclk[0] period 8, 4 high / 4 low
    cfg_we = 1'b1; cfg_ch = 3'd0; cfg_inc = 24'h400000;
    tick();
    cfg_we = 1'b0;
    check("oc_after_wr", 32'(outclk[0]), 32'h0);
    pat_a = '0;
    for (int k = 0; k < 16; k++) begin
      tick();
      pat_a[k] = outclk[0];
    end
    check("oc_pat", 32'(pat_a), 32'h7878);
    ticks(4);
    check("oc_high", 32'(outclk[0]), 32'h1);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    check("oc_clear", 32'(outclk[0]), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
